// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store unit. Sits between the EX_to_MEM and MEM_to_WB
// pipeline registers and drives the data-memory bus with a req/ack
// handshake. Stores get byte-lane steering and lane replication; loads get
// sign/zero extension. The pipeline is stalled while a bus transaction is
// outstanding, and misaligned accesses and bus timeouts are flagged.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   MEM_MemRead_i    load in MEM stage
//   MEM_MemWrite_i   store in MEM stage (wins when both are set)
//   MEM_funct3_i     000 B, 001 H, 010 W, 100 BU, 101 HU, others W
//   MEM_addr_i       byte address from the ALU
//   MEM_wr_data_i    store data (rs2)
//   flush_i          kill the current MEM instruction (sampled in IDLE only)
//   dmem_req_o       bus request, held until ack or timeout
//   dmem_we_o        1 = write
//   dmem_addr_o      word-aligned bus address
//   dmem_be_o        byte enables
//   dmem_wdata_o     lane-replicated store data
//   dmem_ack_i       transfer complete this cycle
//   dmem_rdata_i     read word, valid with ack on a read
//   MEM_rd_data_o    extended load result, held until the next load completes
//   stall_o          freeze PC, IF/ID, ID/EX and EX/MEM
//   misalign_o       misaligned access, one-cycle pulse
//   bus_err_o        bus timeout, one-cycle pulse
//
// The byte-lane logic is written for a 32-bit data bus (4 byte lanes).
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  MEM_MemRead_i,
   input  logic                  MEM_MemWrite_i,
   input  logic [2:0]            MEM_funct3_i,
   input  logic [DATA_WIDTH-1:0] MEM_addr_i,
   input  logic [DATA_WIDTH-1:0] MEM_wr_data_i,
   input  logic                  flush_i,
   output logic                  dmem_req_o,
   output logic                  dmem_we_o,
   output logic [DATA_WIDTH-1:0] dmem_addr_o,
   output logic [3:0]            dmem_be_o,
   output logic [DATA_WIDTH-1:0] dmem_wdata_o,
   input  logic                  dmem_ack_i,
   input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
   output logic [DATA_WIDTH-1:0] MEM_rd_data_o,
   output logic                  stall_o,
   output logic                  misalign_o,
   output logic                  bus_err_o
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, next_state;

   logic                  acc;
   logic                  is_byte;
   logic                  is_half;
   logic                  is_word;
   logic                  misaligned;
   logic                  start;
   logic                  ack_hit;
   logic                  timeout_hit;
   logic [3:0]            be_calc;
   logic [DATA_WIDTH-1:0] wdata_calc;
   logic [7:0]            load_byte;
   logic [15:0]           load_half;
   logic [DATA_WIDTH-1:0] load_ext;
   logic [CNT_W-1:0]      cnt;
   logic [2:0]            funct3_q;
   logic [1:0]            lane_q;

   assign acc = (MEM_MemRead_i | MEM_MemWrite_i) & ~flush_i;

   // funct3[2] only selects signedness, so the size comes from the low two
   // bits; 011/110/111 fall through to word.
   assign is_byte = (MEM_funct3_i[1:0] == 2'b00);
   assign is_half = (MEM_funct3_i[1:0] == 2'b01);
   assign is_word = ~is_byte & ~is_half;

   assign misaligned = (is_half & MEM_addr_i[0]) |
                       (is_word & (MEM_addr_i[1:0] != 2'b00));

   assign start       = (state == IDLE) & acc & ~misaligned;
   assign ack_hit     = (state == REQ) & dmem_ack_i;
   // Last REQ cycle without ack: the request has been held TIMEOUT cycles.
   assign timeout_hit = (state == REQ) & ~dmem_ack_i & (cnt == CNT_LAST);

   // Store-side lane steering: enables and replicated write data
   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = MEM_wr_data_i;
      if (is_byte) begin
         be_calc    = 4'b0001 << MEM_addr_i[1:0];
         wdata_calc = {4{MEM_wr_data_i[7:0]}};
      end else if (is_half) begin
         be_calc    = MEM_addr_i[1] ? 4'b1100 : 4'b0011;
         wdata_calc = {2{MEM_wr_data_i[15:0]}};
      end
   end

   // Load-side lane selection and extension, using the size and lane captured
   // when the request was issued
   always_comb begin
      load_byte = dmem_rdata_i[7:0];
      case (lane_q)
         2'd1:    load_byte = dmem_rdata_i[15:8];
         2'd2:    load_byte = dmem_rdata_i[23:16];
         2'd3:    load_byte = dmem_rdata_i[31:24];
         default: load_byte = dmem_rdata_i[7:0];
      endcase
      load_half = lane_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      case (funct3_q)
         3'b000:  load_ext = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
         3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, load_byte};
         3'b001:  load_ext = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
         3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, load_half};
         default: load_ext = dmem_rdata_i;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; DONE always returns to IDLE so the instruction that
   // arrives after the pipeline advances is evaluated fresh.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = REQ;
         REQ:     if (ack_hit || timeout_hit) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      stall_o    = 1'b0;
      misalign_o = 1'b0;
      case (state)
         IDLE: begin
            stall_o    = start;
            misalign_o = acc & misaligned;
         end
         REQ:     stall_o = 1'b1;
         default: stall_o = 1'b0;
      endcase
   end

   // Cycles spent in REQ; cleared whenever the FSM is elsewhere
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state == REQ) begin
         cnt <= cnt + 1'b1;
      end else begin
         cnt <= '0;
      end
   end

   // Bus outputs are launched from IDLE and then held untouched for the
   // whole transaction, since the bus forbids changing an issued request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_req_o   <= 1'b0;
         dmem_we_o    <= 1'b0;
         dmem_addr_o  <= '0;
         dmem_be_o    <= 4'b0000;
         dmem_wdata_o <= '0;
         funct3_q     <= 3'b000;
         lane_q       <= 2'b00;
      end else if (start) begin
         dmem_req_o   <= 1'b1;
         dmem_we_o    <= MEM_MemWrite_i;
         dmem_addr_o  <= {MEM_addr_i[DATA_WIDTH-1:2], 2'b00};
         dmem_be_o    <= be_calc;
         dmem_wdata_o <= wdata_calc;
         funct3_q     <= MEM_funct3_i;
         lane_q       <= MEM_addr_i[1:0];
      end else if (ack_hit || timeout_hit) begin
         dmem_req_o <= 1'b0;
      end
   end

   // Load result and timeout pulse; stores never touch MEM_rd_data_o
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         MEM_rd_data_o <= '0;
         bus_err_o     <= 1'b0;
      end else begin
         bus_err_o <= timeout_hit;
         if (ack_hit && !dmem_we_o) begin
            MEM_rd_data_o <= load_ext;
         end else if (timeout_hit && !dmem_we_o) begin
            MEM_rd_data_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed vectors for mem_access_unit. Each vector pushes its expected bus
// request, completion and misalign events into queues; an independent
// monitor pops and compares whenever the DUT shows the matching event.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic        flush;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      int          ackDelay;
      bit          expReq;
      bit          expMis;
      logic [31:0] expAddr;
      logic [3:0]  expBe;
      logic        expWe;
      logic [31:0] expWdata;
      logic [31:0] expRd;
      logic        expErr;
      int          expReqCycles;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } bus_exp_t;

   typedef struct {
      string       name;
      logic [31:0] rd;
      logic        err;
      int          stallCycles;
      int          reqCycles;
   } done_exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MEM_MemRead_i;
   logic        MEM_MemWrite_i;
   logic [2:0]  MEM_funct3_i;
   logic [31:0] MEM_addr_i;
   logic [31:0] MEM_wr_data_i;
   logic        flush_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;
   logic [31:0] MEM_rd_data_o;
   logic        stall_o;
   logic        misalign_o;
   logic        bus_err_o;

   int compared   = 0;
   int mismatched = 0;

   bus_exp_t  busQ[$];
   done_exp_t doneQ[$];
   string     misQ[$];

   int          slaveDelay = 0;
   logic [31:0] slaveRdata = 32'h0;

   mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .MEM_MemRead_i  (MEM_MemRead_i),
      .MEM_MemWrite_i (MEM_MemWrite_i),
      .MEM_funct3_i   (MEM_funct3_i),
      .MEM_addr_i     (MEM_addr_i),
      .MEM_wr_data_i  (MEM_wr_data_i),
      .flush_i        (flush_i),
      .dmem_req_o     (dmem_req_o),
      .dmem_we_o      (dmem_we_o),
      .dmem_addr_o    (dmem_addr_o),
      .dmem_be_o      (dmem_be_o),
      .dmem_wdata_o   (dmem_wdata_o),
      .dmem_ack_i     (dmem_ack_i),
      .dmem_rdata_i   (dmem_rdata_i),
      .MEM_rd_data_o  (MEM_rd_data_o),
      .stall_o        (stall_o),
      .misalign_o     (misalign_o),
      .bus_err_o      (bus_err_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   function automatic vec_t mkVec(
      input string name, input logic rd, input logic wr, input logic flush,
      input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
      input logic [31:0] rdata, input int ackDelay, input bit expReq,
      input bit expMis, input logic [31:0] expAddr, input logic [3:0] expBe,
      input logic expWe, input logic [31:0] expWdata, input logic [31:0] expRd,
      input logic expErr, input int expReqCycles);
      vec_t v;
      v.name = name; v.rd = rd; v.wr = wr; v.flush = flush; v.f3 = f3;
      v.addr = addr; v.wd = wd; v.rdata = rdata; v.ackDelay = ackDelay;
      v.expReq = expReq; v.expMis = expMis; v.expAddr = expAddr;
      v.expBe = expBe; v.expWe = expWe; v.expWdata = expWdata;
      v.expRd = expRd; v.expErr = expErr; v.expReqCycles = expReqCycles;
      return v;
   endfunction

   task automatic driveIdle();
      MEM_MemRead_i  = 1'b0;
      MEM_MemWrite_i = 1'b0;
      MEM_funct3_i   = 3'b010;
      MEM_addr_i     = 32'h0;
      MEM_wr_data_i  = 32'h0;
      flush_i        = 1'b0;
   endtask

   // Called just after a rising edge: presents one MEM instruction, keeps it
   // there while the stage is stalled, and returns just after the edge on
   // which the pipeline advances.
   task automatic applyStimulus(input vec_t v);
      bus_exp_t  b;
      done_exp_t d;
      int        n;
      bit        advanced;
      if (v.expReq) begin
         b.name = v.name; b.addr = v.expAddr; b.be = v.expBe;
         b.we = v.expWe; b.wdata = v.expWdata;
         busQ.push_back(b);
         d.name = v.name; d.rd = v.expRd; d.err = v.expErr;
         d.reqCycles = v.expReqCycles; d.stallCycles = v.expReqCycles + 1;
         doneQ.push_back(d);
      end
      if (v.expMis) misQ.push_back(v.name);
      slaveDelay     = v.ackDelay;
      slaveRdata     = v.rdata;
      MEM_MemRead_i  = v.rd;
      MEM_MemWrite_i = v.wr;
      MEM_funct3_i   = v.f3;
      MEM_addr_i     = v.addr;
      MEM_wr_data_i  = v.wd;
      flush_i        = v.flush;
      advanced = 1'b0;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (!stall_o) begin
            advanced = 1'b1;
            break;
         end
      end
      if (!advanced) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL %s_advance: stall_o still 1 after 100 cycles, expected 0", v.name);
      end
      @(posedge clk);
      #1;
   endtask

   // Bus slave: acks in the ackDelay-th request cycle (0 = never ack)
   initial begin
      int reqCount;
      reqCount     = 0;
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (dmem_req_o && rst_n) begin
            reqCount++;
            if (slaveDelay != 0 && reqCount == slaveDelay) begin
               dmem_ack_i   = 1'b1;
               dmem_rdata_i = slaveRdata;
            end else begin
               dmem_ack_i   = 1'b0;
               dmem_rdata_i = ~slaveRdata;
            end
         end else begin
            reqCount     = 0;
            dmem_ack_i   = 1'b0;
            dmem_rdata_i = ~slaveRdata;
         end
      end
   end

   // Monitor: request launch, completion (stall falling) and misalign events
   initial begin
      logic prevReq, prevStall;
      int   stallCnt, reqCnt;
      bus_exp_t  b;
      done_exp_t d;
      string     m;
      prevReq = 1'b0; prevStall = 1'b0; stallCnt = 0; reqCnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prevReq = 1'b0; prevStall = 1'b0; stallCnt = 0; reqCnt = 0;
         end else begin
            if (dmem_req_o && !prevReq) begin
               if (busQ.size() == 0) begin
                  checkOutput("unexpected_req", {31'h0, dmem_req_o}, 32'h0);
               end else begin
                  b = busQ.pop_front();
                  checkOutput({b.name, "_addr"}, dmem_addr_o, b.addr);
                  checkOutput({b.name, "_be"}, {28'h0, dmem_be_o}, {28'h0, b.be});
                  checkOutput({b.name, "_we"}, {31'h0, dmem_we_o}, {31'h0, b.we});
                  if (b.we) checkOutput({b.name, "_wdata"}, dmem_wdata_o, b.wdata);
               end
            end
            if (stall_o) begin
               stallCnt++;
               if (dmem_req_o) reqCnt++;
            end
            if (!stall_o && prevStall) begin
               if (doneQ.size() == 0) begin
                  checkOutput("unexpected_done", {31'h0, prevStall}, 32'h0);
               end else begin
                  d = doneQ.pop_front();
                  checkOutput({d.name, "_rd_data"}, MEM_rd_data_o, d.rd);
                  checkOutput({d.name, "_bus_err"}, {31'h0, bus_err_o}, {31'h0, d.err});
                  checkOutput({d.name, "_stall_cycles"}, stallCnt, d.stallCycles);
                  checkOutput({d.name, "_req_cycles"}, reqCnt, d.reqCycles);
                  checkOutput({d.name, "_req_dropped"}, {31'h0, dmem_req_o}, 32'h0);
               end
               stallCnt = 0;
               reqCnt   = 0;
            end else if (bus_err_o) begin
               checkOutput("spurious_bus_err", {31'h0, bus_err_o}, 32'h0);
            end
            if (misalign_o) begin
               if (misQ.size() == 0) begin
                  checkOutput("unexpected_misalign", {31'h0, misalign_o}, 32'h0);
               end else begin
                  m = misQ.pop_front();
                  checkOutput({m, "_stall"}, {31'h0, stall_o}, 32'h0);
                  checkOutput({m, "_no_req"}, {31'h0, dmem_req_o}, 32'h0);
               end
            end
            prevReq   = dmem_req_o;
            prevStall = stall_o;
         end
      end
   end

   initial begin
      bus_exp_t b;
      rst_n = 1'b0;
      driveIdle();
      repeat (2) @(posedge clk);
      #2;
      checkOutput("reset_req", {31'h0, dmem_req_o}, 32'h0);
      checkOutput("reset_we", {31'h0, dmem_we_o}, 32'h0);
      checkOutput("reset_addr", dmem_addr_o, 32'h0);
      checkOutput("reset_be", {28'h0, dmem_be_o}, 32'h0);
      checkOutput("reset_wdata", dmem_wdata_o, 32'h0);
      checkOutput("reset_rd_data", MEM_rd_data_o, 32'h0);
      checkOutput("reset_stall", {31'h0, stall_o}, 32'h0);
      checkOutput("reset_misalign", {31'h0, misalign_o}, 32'h0);
      checkOutput("reset_bus_err", {31'h0, bus_err_o}, 32'h0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("idle_no_req", {31'h0, dmem_req_o}, 32'h0);
      checkOutput("idle_no_stall", {31'h0, stall_o}, 32'h0);
      @(posedge clk);
      #1;

      //                  name          rd    wr    fl    f3      addr          wd            rdata        dly exReq exMis expAddr       be       we    expWdata      expRd         err  reqCyc
      applyStimulus(mkVec("SW_2000",    1'b0, 1'b1, 1'b0, 3'b010, 32'h00002000, 32'hAABBCCDD, 32'h0,        3, 1, 0, 32'h00002000, 4'b1111, 1'b1, 32'hAABBCCDD, 32'h00000000, 1'b0, 3));
      applyStimulus(mkVec("LB_2003",    1'b1, 1'b0, 1'b0, 3'b000, 32'h00002003, 32'h0,        32'h80FF7F01, 1, 1, 0, 32'h00002000, 4'b1000, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 1));
      applyStimulus(mkVec("LBU_2003",   1'b1, 1'b0, 1'b0, 3'b100, 32'h00002003, 32'h0,        32'h80FF7F01, 1, 1, 0, 32'h00002000, 4'b1000, 1'b0, 32'h0,        32'h00000080, 1'b0, 1));
      applyStimulus(mkVec("LH_2002",    1'b1, 1'b0, 1'b0, 3'b001, 32'h00002002, 32'h0,        32'h80FF7F01, 1, 1, 0, 32'h00002000, 4'b1100, 1'b0, 32'h0,        32'hFFFF80FF, 1'b0, 1));
      applyStimulus(mkVec("LHU_2000",   1'b1, 1'b0, 1'b0, 3'b101, 32'h00002000, 32'h0,        32'h80FF7F01, 2, 1, 0, 32'h00002000, 4'b0011, 1'b0, 32'h0,        32'h00007F01, 1'b0, 2));
      applyStimulus(mkVec("SH_2001mis", 1'b0, 1'b1, 1'b0, 3'b001, 32'h00002001, 32'h00001234, 32'h0,        0, 0, 1, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0,        1'b0, 0));
      applyStimulus(mkVec("LW_2002mis", 1'b1, 1'b0, 1'b0, 3'b010, 32'h00002002, 32'h0,        32'h0,        0, 0, 1, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0,        1'b0, 0));
      applyStimulus(mkVec("LW_timeout", 1'b1, 1'b0, 1'b0, 3'b010, 32'h00003000, 32'h0,        32'h0,        0, 1, 0, 32'h00003000, 4'b1111, 1'b0, 32'h0,        32'h00000000, 1'b1, 16));
      applyStimulus(mkVec("SW_flush",   1'b0, 1'b1, 1'b1, 3'b010, 32'h00002000, 32'h12345678, 32'h0,        0, 0, 0, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0,        1'b0, 0));
      driveIdle();
      @(posedge clk);
      #1;
      applyStimulus(mkVec("LW_100",     1'b1, 1'b0, 1'b0, 3'b010, 32'h00000100, 32'h0,        32'h11223344, 1, 1, 0, 32'h00000100, 4'b1111, 1'b0, 32'h0,        32'h11223344, 1'b0, 1));
      applyStimulus(mkVec("LW_104",     1'b1, 1'b0, 1'b0, 3'b010, 32'h00000104, 32'h0,        32'h55667788, 1, 1, 0, 32'h00000104, 4'b1111, 1'b0, 32'h0,        32'h55667788, 1'b0, 1));
      applyStimulus(mkVec("SB_2001",    1'b0, 1'b1, 1'b0, 3'b000, 32'h00002001, 32'h000000A5, 32'h0,        2, 1, 0, 32'h00002000, 4'b0010, 1'b1, 32'hA5A5A5A5, 32'h55667788, 1'b0, 2));
      applyStimulus(mkVec("SH_2002",    1'b0, 1'b1, 1'b0, 3'b001, 32'h00002002, 32'h1234BEEF, 32'h0,        1, 1, 0, 32'h00002000, 4'b1100, 1'b1, 32'hBEEFBEEF, 32'h55667788, 1'b0, 1));
      applyStimulus(mkVec("LB_2001",    1'b1, 1'b0, 1'b0, 3'b000, 32'h00002001, 32'h0,        32'h80FF7F01, 1, 1, 0, 32'h00002000, 4'b0010, 1'b0, 32'h0,        32'h0000007F, 1'b0, 1));
      applyStimulus(mkVec("SW_timeout", 1'b0, 1'b1, 1'b0, 3'b010, 32'h00002010, 32'h0BADF00D, 32'h0,        0, 1, 0, 32'h00002010, 4'b1111, 1'b1, 32'h0BADF00D, 32'h0000007F, 1'b1, 16));
      applyStimulus(mkVec("LDST_2004",  1'b1, 1'b1, 1'b0, 3'b010, 32'h00002004, 32'hCAFEF00D, 32'h12345678, 1, 1, 0, 32'h00002004, 4'b1111, 1'b1, 32'hCAFEF00D, 32'h0000007F, 1'b0, 1));
      applyStimulus(mkVec("LW011_2008", 1'b1, 1'b0, 1'b0, 3'b011, 32'h00002008, 32'h0,        32'hDEADBEEF, 1, 1, 0, 32'h00002008, 4'b1111, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1));
      driveIdle();
      repeat (3) @(posedge clk);
      #1;

      // Asynchronous reset while a request is outstanding
      b.name = "LW_400_rst"; b.addr = 32'h00000400; b.be = 4'b1111;
      b.we = 1'b0; b.wdata = 32'h0;
      busQ.push_back(b);
      slaveDelay     = 0;
      MEM_MemRead_i  = 1'b1;
      MEM_funct3_i   = 3'b010;
      MEM_addr_i     = 32'h00000400;
      repeat (3) @(posedge clk);
      #3;
      driveIdle();
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_req", {31'h0, dmem_req_o}, 32'h0);
      checkOutput("async_rst_stall", {31'h0, stall_o}, 32'h0);
      checkOutput("async_rst_rd_data", MEM_rd_data_o, 32'h0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("post_rst_no_req", {31'h0, dmem_req_o}, 32'h0);
      checkOutput("busQ_empty", busQ.size(), 32'd0);
      checkOutput("doneQ_empty", doneQ.size(), 32'd0);
      checkOutput("misQ_empty", misQ.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store unit. It sits between the EX_to_MEM and MEM_to_WB pipeline registers and drives the data-memory bus through a req/ack handshake. It performs byte-lane steering for stores and sign/zero extension for loads, and produces MEM_rd_data_o, which feeds MEM_to_WB's MEM_rd_data_i. It stalls the pipeline while a bus transaction is outstanding, and flags misaligned accesses and bus timeouts.

Parameters:
DATA_WIDTH, 32, data and address width (shared defines value)
TIMEOUT, 16, maximum cycles in REQ waiting for dmem_ack_i before abort (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
MEM_MemRead_i  in  1  load in MEM stage
MEM_MemWrite_i  in  1  store in MEM stage
MEM_funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 decode as W
MEM_addr_i  in  DATA_WIDTH  byte address (ALU result)
MEM_wr_data_i  in  DATA_WIDTH  store data (rs2)
flush_i  in  1  kill the current MEM instruction
dmem_req_o  out  1  bus request, held until ack
dmem_we_o  out  1  1 = write
dmem_addr_o  out  DATA_WIDTH  word-aligned address ({addr[31:2],2'b00})
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  DATA_WIDTH  lane-replicated store data
dmem_ack_i  in  1  transfer complete this cycle
dmem_rdata_i  in  DATA_WIDTH  read word, valid when ack=1 and we=0
MEM_rd_data_o  out  DATA_WIDTH  extended load result
stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
misalign_o  out  1  misaligned access (1-cycle pulse)
bus_err_o  out  1  bus timeout (1-cycle pulse)

Behaviour:
- Reset: state IDLE. All outputs 0: dmem_* outputs, MEM_rd_data_o, stall_o, misalign_o, bus_err_o. Timeout counter 0.
- acc = (MemRead|MemWrite) & ~flush_i. If both MemRead and MemWrite are set, the access is a store.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- Byte enables:
  - B/BU: 1<<addr[1:0]
  - H/HU: addr[1] ? 1100 : 0011
  - W: 1111
- Store data: SB replicates {4{wd[7:0]}}; SH replicates {2{wd[15:0]}}; SW passes wd unchanged.
- FSM IDLE -> REQ -> DONE -> IDLE. Each state:
  - IDLE, acc & aligned: stall_o=1 (combinational). Register addr, be, we and wdata onto the dmem_* outputs, set dmem_req_o=1, go to REQ.
  - IDLE, acc & misaligned: no request. misalign_o=1 for this cycle, stall_o=0, stay in IDLE.
  - IDLE, no acc: stall_o=0.
  - REQ: dmem_req_o and all dmem_* outputs held stable. stall_o=1. Counter increments each cycle.
    - On dmem_ack_i: drop req. For a load, register the extended result into MEM_rd_data_o. Go to DONE.
    - Counter reaching TIMEOUT without ack: drop req, bus_err_o=1, MEM_rd_data_o=0, go to DONE.
  - DONE: stall_o=0 for exactly one cycle so the pipeline advances. Return to IDLE. The incoming instruction is not started in this cycle; it is evaluated in IDLE.
- Load extension: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
- MEM_rd_data_o holds its value until the next load completes; stores and timeouts on stores leave it unchanged.
- flush_i is sampled only in IDLE. An issued request is never withdrawn, because the bus protocol forbids it.
- Minimum latency: 2 stall cycles (acc seen in IDLE; ack in the first REQ cycle). Result is valid in the DONE cycle.
- Asynchronous reset in REQ: req drops immediately and the FSM goes to IDLE. The bus slave must tolerate this.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> all outputs 0, stall_o=0. Release, idle inputs -> no dmem_req_o.
- SW addr=0x2000, wd=0xAABBCCDD, ack after 3 cycles -> dmem_addr=0x2000, be=1111, wdata=0xAABBCCDD, we=1. stall_o high for 4 cycles, then low for one DONE cycle.
- LB addr=0x2003, rdata=0x80FF7F01, ack immediate -> be=1000, MEM_rd_data_o=0xFFFFFF80. Same access as LBU -> 0x00000080. LH addr=0x2002 -> 0xFFFF80FF.
- SH addr=0x2001 -> misalign_o pulses 1 cycle, no dmem_req_o, stall_o=0. LW addr=0x2002 -> same result.
- LW with no ack, TIMEOUT=16 -> req held 16 cycles, then bus_err_o pulses, MEM_rd_data_o=0, stall_o drops after DONE.
- Flush and back-to-back:
  - flush_i=1 with SW -> no request.
  - LW 0x100 then LW 0x104, both acked immediately -> two separate REQ/DONE sequences, MEM_rd_data_o updates in each DONE cycle.
